uart_tx_loader: RTL and testbench
=================================

// Module: uart_tx_loader
// PURPOSE
//   UART 8N1 transmitter: the sending end of the serial link that feeds top_sim's uart_serial input.
//   Used by host-side benches and the board loader path to stream program bytes into the core.
//   Includes a small byte FIFO, so a producer can queue bytes with valid/ready while frames go out back-to-back.
// PARAMETERS
//   CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); legal range >= 2
//   FIFO_DEPTH    4    byte FIFO entries; power of 2, >= 2
// PORTS
//   clk         in   1                      system clock, rising edge
//   rst         in   1                      reset, asynchronous, active-low (0 = reset)
//   tx_data     in   8                      byte to send
//   tx_valid    in   1                      tx_data valid
//   tx_ready    out  1                      FIFO can accept a byte this cycle
//   tx_serial   out  1                      UART line, idle high, registered
//   busy        out  1                      frame in progress (state != IDLE)
//   fifo_count  out  $clog2(FIFO_DEPTH)+1   bytes queued, not including the byte being shifted
// BEHAVIOUR
//   - Reset (rst=0, async): tx_serial=1, busy=0, fifo_count=0, FIFO pointers=0, state=IDLE.
//     tx_ready=1 while out of reset and the FIFO is empty.
//   - Reset mid-frame aborts immediately: line goes high asynchronously; in-flight byte and queued bytes are discarded.
//   - Push: occurs on the edge where tx_valid && tx_ready.
//     tx_ready = (fifo_count < FIFO_DEPTH), decoded from registered count only, with no combinational path from tx_valid.
//   - Full FIFO: tx_ready=0 and tx_valid is ignored. When a pop frees a slot, tx_ready rises the next cycle.
//   - Push and pop on the same edge: fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
//   - FSM states: IDLE, START, DATA, STOP (plus PARITY under the macro).
//     - IDLE: tx_serial=1. If fifo_count!=0, pop the head into an 8-bit shift reg and go to START.
//     - START: tx_serial=0 for CLKS_PER_BIT cycles, then DATA.
//     - DATA: tx_serial=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then shift right.
//       After bit index 7, go to STOP (or PARITY).
//     - STOP: tx_serial=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go straight
//       to START (no idle gap); else go to IDLE.
//   - Baud counter runs 0..CLKS_PER_BIT-1, wraps, and restarts at 0 on every state entry.
//     Bit index is 3 bits, cleared on START exit.
//   - Latency: byte pushed on edge N into an empty FIFO while IDLE -> pop at edge N+1, tx_serial low from edge N+1.
//     fifo_count reads 1 for exactly one cycle.
//   - Frame length = 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
//     Back-to-back frames have zero idle cycles between stop and next start.
//   - busy=1 from the pop edge until the edge returning to IDLE.
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//     - PARITY state inserted between DATA and STOP.
//     - Drives even parity bit = ^byte for CLKS_PER_BIT cycles; frame = 11 bits.
//   Undefined:
//     - No PARITY state, no parity logic; 8N1 only.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4)
//   1. After reset, push 0x55 at edge N.
//      -> tx_serial low edges N+1..N+4, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles.
//      -> busy falls at edge N+41; fifo_count returns to 0 at N+1.
//   2. Push 0xA5,0x3C,0xFF,0x00,0x81 on consecutive cycles.
//      -> 0xA5 is popped at once, so 0x3C,0xFF,0x00,0x81 fill the FIFO: fifo_count reaches 4 and tx_ready drops.
//      -> 5 frames go out back-to-back (200 cycles), in order, with no high gap >4 cycles.
//   3. With the FIFO full, hold tx_valid=1 with 0x77.
//      -> not accepted until tx_ready=1.
//      -> 0x77 is then the 6th frame; no byte duplicated or lost.
//   4. Drive rst=0 mid-DATA of 0xF0 with 2 bytes queued.
//      -> tx_serial=1, fifo_count=0, busy=0 immediately.
//      -> After release, the line stays high with no spurious frame.
//   5. [UART_TX_PARITY_EN] send 0x07, then 0x03.
//      -> parity bit is 1, then 0; each frame is 44 cycles.
//   6. Push and pop on the same edge (push lands on the stop-to-start pop edge, 2 queued).
//      -> fifo_count stays 2; order preserved.

Source files
------------

// File: rtl/uart_tx_loader.sv
// uart_tx_loader: 8N1 UART transmitter fed by a small valid/ready byte FIFO, frames go out back-to-back.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1 frames).

module uart_tx_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_serial,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // ---------------- byte FIFO ----------------
  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  logic                       push, pop;
  logic [7:0]                 head;

  // Ready comes from the registered count only, so tx_valid never loops back into tx_ready.
  assign tx_ready   = (count < DEPTH_C);
  assign push       = tx_valid && tx_ready;
  assign fifo_count = count;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- frame FSM ----------------
  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          ser_n;
  logic          baud_done, head_avail;
`ifdef UART_TX_PARITY_EN
  logic          par, par_n;
`endif

  assign baud_done  = (baud == BAUD_LAST);
  assign head_avail = (count != '0);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      tx_serial <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      baud      <= baud_n;
      bit_idx   <= bit_n;
      shift     <= shift_n;
      tx_serial <= ser_n;
`ifdef UART_TX_PARITY_EN
      par       <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud + BW'(1);
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        baud_n = '0;
        if (head_avail) begin
          pop     = 1'b1;
          shift_n = head;
`ifdef UART_TX_PARITY_EN
          par_n   = ^head;
`endif
          state_n = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n  = '0;
          shift_n = {1'b0, shift[7:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_n  = '0;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          baud_n = '0;
          // Chain straight into the next start bit when a byte is waiting.
          if (head_avail) begin
            pop     = 1'b1;
            shift_n = head;
`ifdef UART_TX_PARITY_EN
            par_n   = ^head;
`endif
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        baud_n  = '0;
        state_n = IDLE;
      end
    endcase

    // Line level is registered from the next state so it changes on the same edge as the state.
    case (state_n)
      START:   ser_n = 1'b0;
      DATA:    ser_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  ser_n = par_n;
`endif
      default: ser_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_loader.sv
// Directed bench for uart_tx_loader (CLKS_PER_BIT=4, FIFO_DEPTH=4); a line receiver decodes frames.
// Parity scenario is compiled in only with UART_TX_PARITY_EN.

module tb_uart_tx_loader;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_serial, busy;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  int         rx_start_q[$];
  logic       rx_par_q[$];
  int         rx_bad = 0;
  logic [7:0] rx_d;
  int         rx_s;
  logic       rx_ok;

  uart_tx_loader #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_serial(tx_serial), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver: start seen on the first low sample, then samples each bit mid-period.
  initial begin : rx_model
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx_serial === 1'b0) begin
        rx_s  = cyc;
        rx_ok = 1'b1;
        repeat (CPB/2) @(negedge clk);
        if (tx_serial !== 1'b0) rx_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx_d[i] = tx_serial;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        rx_par_q.push_back(tx_serial);
`endif
        repeat (CPB) @(negedge clk);
        if (tx_serial !== 1'b1) rx_ok = 1'b0;
        repeat (CPB/2 - 1) @(negedge clk);
        rx_q.push_back(rx_d);
        rx_start_q.push_back(rx_s);
        if (!rx_ok) rx_bad++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  function automatic logic exp_line(input logic [7:0] b, input int k);
    if (k < 1)       return 1'b1;
    if (k <= CPB)    return 1'b0;
    if (k <= 9*CPB)  return b[(k - CPB - 1) / CPB];
`ifdef UART_TX_PARITY_EN
    if (k <= 10*CPB) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic clear_rx;
    rx_q.delete();
    rx_start_q.delete();
    rx_par_q.delete();
    rx_bad = 0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL reset_line got=%b want=1", tx_serial); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", tx_ready); end
    checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL reset_idle_line got=%b want=1", tx_serial); end
  endtask

  task automatic test_single;
    logic [7:0] b;
    logic       e_ser, e_busy;
    int         e_cnt;
    b = 8'h55;
    repeat (4) @(posedge clk);
    #1;
    tx_data = b; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int k = 0; k <= FRAME + 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      e_ser  = exp_line(b, k);
      e_busy = (k >= 1 && k <= FRAME);
      e_cnt  = (k == 0) ? 1 : 0;
      checks++; if (tx_serial !== e_ser) begin errors++; $display("FAIL single_line k=%0d got=%b want=%b", k, tx_serial, e_ser); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL single_busy k=%0d got=%b want=%b", k, busy, e_busy); end
      checks++; if (fifo_count !== e_cnt) begin errors++; $display("FAIL single_count k=%0d got=%0d want=%0d", k, fifo_count, e_cnt); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] vec [6];
    int         exp_cnt [5];
    int         n, acc, t;
    logic       r;
    vec     = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h77};
    exp_cnt = '{1, 1, 2, 3, 4};
    n = 0;
    repeat (4) @(posedge clk);
    #1;
    clear_rx();
    for (int i = 0; i < 5; i++) begin
      tx_data = vec[i]; tx_valid = 1'b1;
      @(posedge clk); #1;
      if (i == 0) n = cyc;
      checks++; if (fifo_count !== exp_cnt[i]) begin errors++; $display("FAIL b2b_count i=%0d got=%0d want=%0d", i, fifo_count, exp_cnt[i]); end
    end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got=%b want=0", tx_ready); end
    // Hold 0x77 on the bus while full; it must wait for the first stop-to-start pop.
    tx_data = vec[5];
    acc = -1; t = 0;
    while (acc < 0 && t < 4*FRAME) begin
      @(negedge clk); r = tx_ready;
      @(posedge clk); #1; t++;
      if (r) acc = cyc;
    end
    tx_valid = 1'b0;
    checks++; if (acc !== n + 2 + FRAME) begin errors++; $display("FAIL hold_accept_edge got=%0d want=%0d", acc - n, 2 + FRAME); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL hold_count got=%0d want=4", fifo_count); end
    wait_rx(6, 8*FRAME);
    checks++; if (rx_q.size() !== 6) begin errors++; $display("FAIL b2b_frames got=%0d want=6", rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== vec[i]) begin errors++; $display("FAIL b2b_byte i=%0d got=%h want=%h", i, rx_q[i], vec[i]); end
    end
    if (rx_start_q.size() > 0) begin
      checks++; if (rx_start_q[0] !== n + 1) begin errors++; $display("FAIL b2b_first_start got=%0d want=1", rx_start_q[0] - n); end
    end
    for (int i = 1; i < rx_start_q.size(); i++) begin
      checks++; if (rx_start_q[i] - rx_start_q[i-1] !== FRAME) begin errors++; $display("FAIL b2b_spacing i=%0d got=%0d want=%0d", i, rx_start_q[i] - rx_start_q[i-1], FRAME); end
    end
    checks++; if (rx_bad !== 0) begin errors++; $display("FAIL b2b_framing got=%0d want=0", rx_bad); end
  endtask

  task automatic test_reset_mid_frame;
    repeat (4) @(posedge clk);
    #1;
    clear_rx();
    tx_data = 8'hF0; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'h11;
    @(posedge clk); #1;
    tx_data = 8'h22;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    // Land inside data bit 2 of 0xF0 (a low bit).
    repeat (13) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got=%b want=1", busy); end
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL midrst_pre_count got=%0d want=2", fifo_count); end
    checks++; if (tx_serial !== 1'b0) begin errors++; $display("FAIL midrst_pre_line got=%b want=0", tx_serial); end
    #2 rst = 1'b0;
    #1;
    checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL midrst_line got=%b want=1", tx_serial); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL midrst_count got=%0d want=0", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      checks++; if (tx_serial !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
        errors++; $display("FAIL midrst_quiet k=%0d got line=%b busy=%b count=%0d want 1/0/0", k, tx_serial, busy, fifo_count);
      end
    end
    clear_rx();
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    int n;
    repeat (4) @(posedge clk);
    #1;
    clear_rx();
    tx_data = 8'h07; tx_valid = 1'b1;
    @(posedge clk); #1;
    n = cyc;
    tx_data = 8'h03;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_rx(2, 4*FRAME);
    checks++; if (rx_q.size() !== 2 || rx_par_q.size() !== 2) begin errors++; $display("FAIL par_frames got=%0d want=2", rx_q.size()); end
    if (rx_q.size() == 2 && rx_par_q.size() == 2) begin
      checks++; if (rx_q[0] !== 8'h07) begin errors++; $display("FAIL par_byte0 got=%h want=07", rx_q[0]); end
      checks++; if (rx_q[1] !== 8'h03) begin errors++; $display("FAIL par_byte1 got=%h want=03", rx_q[1]); end
      checks++; if (rx_par_q[0] !== 1'b1) begin errors++; $display("FAIL par_bit0 got=%b want=1", rx_par_q[0]); end
      checks++; if (rx_par_q[1] !== 1'b0) begin errors++; $display("FAIL par_bit1 got=%b want=0", rx_par_q[1]); end
      checks++; if (rx_start_q[0] !== n + 1) begin errors++; $display("FAIL par_first_start got=%0d want=1", rx_start_q[0] - n); end
      checks++; if (rx_start_q[1] - rx_start_q[0] !== 44) begin errors++; $display("FAIL par_frame_len got=%0d want=44", rx_start_q[1] - rx_start_q[0]); end
    end
    checks++; if (rx_bad !== 0) begin errors++; $display("FAIL par_framing got=%0d want=0", rx_bad); end
  endtask
`endif

  task automatic test_push_pop_same_edge;
    logic [7:0] vec [4];
    int         n;
    vec = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    repeat (4) @(posedge clk);
    #1;
    clear_rx();
    tx_data = vec[0]; tx_valid = 1'b1;
    @(posedge clk); #1;
    n = cyc;
    tx_data = vec[1];
    @(posedge clk); #1;
    tx_data = vec[2];
    @(posedge clk); #1;
    tx_valid = 1'b0;
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL pp_setup_count got=%0d want=2", fifo_count); end
    while (cyc < n + FRAME) begin @(posedge clk); #1; end
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL pp_pre_count got=%0d want=2", fifo_count); end
    tx_data = vec[3]; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL pp_edge_count got=%0d want=2", fifo_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pp_busy got=%b want=1", busy); end
    @(posedge clk); #1;
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL pp_post_count got=%0d want=2", fifo_count); end
    wait_rx(4, 6*FRAME);
    checks++; if (rx_q.size() !== 4) begin errors++; $display("FAIL pp_frames got=%0d want=4", rx_q.size()); end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== vec[i]) begin errors++; $display("FAIL pp_byte i=%0d got=%h want=%h", i, rx_q[i], vec[i]); end
    end
    for (int i = 1; i < rx_start_q.size(); i++) begin
      checks++; if (rx_start_q[i] - rx_start_q[i-1] !== FRAME) begin errors++; $display("FAIL pp_spacing i=%0d got=%0d want=%0d", i, rx_start_q[i] - rx_start_q[i-1], FRAME); end
    end
    checks++; if (rx_bad !== 0) begin errors++; $display("FAIL pp_framing got=%0d want=0", rx_bad); end
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_push_pop_same_edge();
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
